// File: rtl/char_conv_pkg.sv
// Shared types and constants for the character case-conversion arbiter.
package char_conv_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_UPPER  = 2'd1,
    MODE_LOWER  = 2'd2,
    MODE_TOGGLE = 2'd3
  } conv_mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam logic [7:0] CASE_DELTA = 8'h20;
  localparam logic [7:0] LC_A       = 8'h61;
  localparam logic [7:0] LC_Z       = 8'h7A;
  localparam logic [7:0] UC_A       = 8'h41;
  localparam logic [7:0] UC_Z       = 8'h5A;

endpackage

// File: rtl/char_case_conv.sv
// Combinational ASCII case converter; bytes outside A-Z / a-z always pass unchanged.
module char_case_conv
  import char_conv_pkg::*;
(
  input  logic [7:0] i_char,
  input  logic [1:0] i_mode,
  output logic [7:0] o_char
);

  logic is_lc;
  logic is_uc;

  assign is_lc = (i_char >= LC_A) && (i_char <= LC_Z);
  assign is_uc = (i_char >= UC_A) && (i_char <= UC_Z);

  always_comb begin
    o_char = i_char;
    case (conv_mode_e'(i_mode))
      MODE_UPPER: begin
        if (is_lc) o_char = i_char - CASE_DELTA;
      end
      MODE_LOWER: begin
        if (is_uc) o_char = i_char + CASE_DELTA;
      end
      MODE_TOGGLE: begin
        if (is_lc)      o_char = i_char - CASE_DELTA;
        else if (is_uc) o_char = i_char + CASE_DELTA;
      end
      default: o_char = i_char;
    endcase
  end

endmodule

// File: rtl/char_conv_arbiter.sv
// Round-robin, message-locked arbiter feeding one case converter and a
// single registered valid/ready output stage.
module char_conv_arbiter
  import char_conv_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_SRC-1:0] i_src_valid,
  input  logic [7:0]         i_src_char [NUM_SRC],
  input  logic [NUM_SRC-1:0] i_src_last,
  output logic [NUM_SRC-1:0] o_src_ready,
  input  logic [1:0]         i_mode [NUM_SRC],
  output logic               o_valid,
  output logic [7:0]         o_char,
  output logic               o_last,
  output logic [SRC_W-1:0]   o_src,
  input  logic               i_ready
);

  arb_state_e       state_q, state_d;
  logic [SRC_W-1:0] rr_q, rr_d;
  logic [SRC_W-1:0] owner_q, owner_d;
  logic [SRC_W-1:0] sel;
  logic [SRC_W-1:0] cand;
  logic             found;
  logic             can_load;
  logic             accept;
  logic [7:0]       conv_char;

  logic             valid_q, valid_d;
  logic [7:0]       char_q, char_d;
  logic             last_q, last_d;
  logic [SRC_W-1:0] src_q, src_d;

  // Descending scan so the candidate closest to rr_q is written last and wins.
  always_comb begin
    sel   = owner_q;
    found = 1'b0;
    cand  = '0;
    if (state_q == ST_LOCKED) begin
      found = 1'b1;
    end else begin
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
        cand = SRC_W'((int'(rr_q) + k) % NUM_SRC);
        if (i_src_valid[cand]) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end
  end

  assign can_load = !valid_q || i_ready;
  assign accept   = !i_rst && can_load && found && i_src_valid[sel];

  always_comb begin
    o_src_ready = '0;
    if (!i_rst && can_load && found) o_src_ready[sel] = 1'b1;
  end

  char_case_conv u_conv (
    .i_char (i_src_char[sel]),
    .i_mode (i_mode[sel]),
    .o_char (conv_char)
  );

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    valid_d = valid_q;
    char_d  = char_q;
    last_d  = last_q;
    src_d   = src_q;
    if (accept) begin
      valid_d = 1'b1;
      char_d  = conv_char;
      last_d  = i_src_last[sel];
      src_d   = sel;
      if (i_src_last[sel]) begin
        state_d = ST_IDLE;
        rr_d    = (sel == SRC_W'(NUM_SRC - 1)) ? '0 : sel + 1'b1;
      end else begin
        state_d = ST_LOCKED;
        owner_d = sel;
      end
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      valid_q <= 1'b0;
      char_q  <= '0;
      last_q  <= 1'b0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      valid_q <= valid_d;
      char_q  <= char_d;
      last_q  <= last_d;
      src_q   <= src_d;
    end
  end

  assign o_valid = valid_q;
  assign o_char  = char_q;
  assign o_last  = last_q;
  assign o_src   = src_q;

endmodule
